// File: rtl/pipeline_hazard_ctrl_pkg.sv
// core_pkg: shared types and constants for the RV32 pipeline control logic.
//   mc_state_t      : multi-cycle handshake FSM states (IDLE, BUSY)
//   RESULT_SRC_LOAD : result_src encoding that marks a load in Execute
//   REG_ZERO        : architectural x0, never a real data dependency
package core_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mc_state_t;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;
  localparam logic [4:0] REG_ZERO        = 5'd0;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// sat_counter: saturating up-counter for performance statistics.
//   clk_i  : clock
//   rst_i  : asynchronous active-high reset, clears the count
//   clr_i  : synchronous clear, wins over inc_i
//   inc_i  : count one event this cycle
//   cnt_o  : current count, sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  // Clear beats increment; once all-ones the count holds so a long
  // stall never reads back as a small number.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_o <= '0;
    end else if (clr_i) begin
      cnt_o <= '0;
    end else if (inc_i && (cnt_o != {W{1'b1}})) begin
      cnt_o <= cnt_o + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush scheduler for the 5-stage RV32 pipeline.
// Inputs : clk_i, rst_i (async, active-high), Decode sources rs1_d_i/rs2_d_i,
//          Execute rd_e_i/result_src_e_i/pc_src_e_i/mc_op_e_i, mc_done_i
//          from the multi-cycle unit, cnt_clr_i for the stall counter.
// Outputs: stall_f_o/stall_d_o/stall_e_o, flush_d_o/flush_e_o/flush_m_o,
//          mc_start_o and mc_err_o to the multi-cycle unit, stall_cnt_o.
// All hazard outputs are combinational from inputs and FSM state.
module pipeline_hazard_ctrl
  import core_pkg::*;
#(
  parameter int MC_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       rs1_d_i,
  input  logic [4:0]       rs2_d_i,
  input  logic [4:0]       rd_e_i,
  input  logic [1:0]       result_src_e_i,
  input  logic             pc_src_e_i,
  input  logic             mc_op_e_i,
  input  logic             mc_done_i,
  input  logic             cnt_clr_i,
  output logic             stall_f_o,
  output logic             stall_d_o,
  output logic             stall_e_o,
  output logic             flush_d_o,
  output logic             flush_e_o,
  output logic             flush_m_o,
  output logic             mc_start_o,
  output logic             mc_err_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam int             TO_W   = $clog2(MC_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_VAL = TO_W'(MC_TIMEOUT);

  mc_state_t       state_q, state_d;
  logic [TO_W-1:0] to_cnt_q;
  logic            mc_req;
  logic            mc_timeout;
  logic            mc_busy;
  logic            load_use;

  // FSM register, BUSY-cycle counter and the registered timeout pulse.
  // The counter is 1 in the first BUSY cycle, so reaching MC_TIMEOUT means
  // the pipeline has been held for exactly MC_TIMEOUT cycles including the
  // start cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      to_cnt_q <= '0;
      mc_err_o <= 1'b0;
    end else begin
      state_q  <= state_d;
      mc_err_o <= mc_timeout;
      if (state_q == IDLE && mc_req) begin
        to_cnt_q <= TO_W'(1);
      end else if (state_q == BUSY && !mc_done_i && !mc_timeout) begin
        to_cnt_q <= to_cnt_q + 1'b1;
      end
    end
  end

  // Next state, multi-cycle busy and output priority. The request is masked
  // while reset is held so an op left in Execute cannot fire a start pulse
  // before reset is released. The timeout cycle and the done cycle both
  // release the pipeline so E/M captures on that edge.
  always_comb begin
    state_d    = state_q;
    stall_f_o  = 1'b0;
    stall_d_o  = 1'b0;
    stall_e_o  = 1'b0;
    flush_d_o  = 1'b0;
    flush_e_o  = 1'b0;
    flush_m_o  = 1'b0;

    mc_req     = mc_op_e_i && !rst_i;
    mc_timeout = (state_q == BUSY) && (to_cnt_q == TO_VAL) && !mc_done_i;
    mc_start_o = (state_q == IDLE) && mc_req;
    mc_busy    = mc_start_o || ((state_q == BUSY) && !mc_done_i && !mc_timeout);
    load_use   = (result_src_e_i == RESULT_SRC_LOAD) && (rd_e_i != REG_ZERO) &&
                 ((rd_e_i == rs1_d_i) || (rd_e_i == rs2_d_i));

    case (state_q)
      IDLE:    if (mc_req) state_d = BUSY;
      BUSY:    if (mc_done_i || mc_timeout) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (mc_busy) begin
      stall_f_o = 1'b1;
      stall_d_o = 1'b1;
      stall_e_o = 1'b1;
      flush_m_o = 1'b1;
    end else if (pc_src_e_i) begin
      flush_d_o = 1'b1;
      flush_e_o = 1'b1;
    end else if (load_use) begin
      stall_f_o = 1'b1;
      stall_d_o = 1'b1;
      flush_e_o = 1'b1;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (cnt_clr_i),
    .inc_i (stall_f_o),
    .cnt_o (stall_cnt_o)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed bench for pipeline_hazard_ctrl with
// MC_TIMEOUT=4 and CNT_W=4. Inputs change on the falling edge; outputs are
// checked 1ns later, so registered values reflect the preceding rising edge.
module tb_pipeline_hazard_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [4:0] rs1_d_i, rs2_d_i, rd_e_i;
  logic [1:0] result_src_e_i;
  logic       pc_src_e_i, mc_op_e_i, mc_done_i, cnt_clr_i;
  logic       stall_f_o, stall_d_o, stall_e_o;
  logic       flush_d_o, flush_e_o, flush_m_o;
  logic       mc_start_o, mc_err_o;
  logic [3:0] stall_cnt_o;

  // Packed view: {stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, start}
  logic [6:0] outs;
  assign outs = {stall_f_o, stall_d_o, stall_e_o, flush_d_o, flush_e_o,
                 flush_m_o, mc_start_o};

  localparam logic [6:0] O_NONE  = 7'b0000000;
  localparam logic [6:0] O_LU    = 7'b1100100;
  localparam logic [6:0] O_BR    = 7'b0001100;
  localparam logic [6:0] O_START = 7'b1110011;
  localparam logic [6:0] O_BUSY  = 7'b1110010;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk_i = ~clk_i;

  pipeline_hazard_ctrl #(
    .MC_TIMEOUT(4),
    .CNT_W     (4)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .rs1_d_i        (rs1_d_i),
    .rs2_d_i        (rs2_d_i),
    .rd_e_i         (rd_e_i),
    .result_src_e_i (result_src_e_i),
    .pc_src_e_i     (pc_src_e_i),
    .mc_op_e_i      (mc_op_e_i),
    .mc_done_i      (mc_done_i),
    .cnt_clr_i      (cnt_clr_i),
    .stall_f_o      (stall_f_o),
    .stall_d_o      (stall_d_o),
    .stall_e_o      (stall_e_o),
    .flush_d_o      (flush_d_o),
    .flush_e_o      (flush_e_o),
    .flush_m_o      (flush_m_o),
    .mc_start_o     (mc_start_o),
    .mc_err_o       (mc_err_o),
    .stall_cnt_o    (stall_cnt_o)
  );

  // Move to the next falling edge with all stimulus idle.
  task automatic next_cycle_idle();
    @(negedge clk_i);
    rs1_d_i = 5'd0; rs2_d_i = 5'd0; rd_e_i = 5'd0; result_src_e_i = 2'b00;
    pc_src_e_i = 1'b0; mc_op_e_i = 1'b0; mc_done_i = 1'b0; cnt_clr_i = 1'b0;
  endtask

  // Zero the stall counter through the synchronous clear.
  task automatic clear_counter();
    next_cycle_idle();
    cnt_clr_i = 1'b1;
    next_cycle_idle();
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    rs1_d_i = 5'd0; rs2_d_i = 5'd0; rd_e_i = 5'd0; result_src_e_i = 2'b00;
    pc_src_e_i = 1'b0; mc_op_e_i = 1'b0; mc_done_i = 1'b0; cnt_clr_i = 1'b0;
    #3;
    tests_run++;
    if (outs !== O_NONE || mc_err_o !== 1'b0 || stall_cnt_o !== 4'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset: outs=%b err=%b cnt=%0d, expected outs=%b err=0 cnt=0",
               outs, mc_err_o, stall_cnt_o, O_NONE);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic test_load_use();
    clear_counter();
    result_src_e_i = 2'b01; rd_e_i = 5'd5; rs1_d_i = 5'd3; rs2_d_i = 5'd5;
    #1;
    tests_run++;
    if (outs !== O_LU) begin
      tests_failed++;
      $display("[TB] FAIL load_use_rs2: outs=%b expected %b", outs, O_LU);
    end
    next_cycle_idle();
    result_src_e_i = 2'b01; rd_e_i = 5'd0; rs1_d_i = 5'd0; rs2_d_i = 5'd0;
    #1;
    tests_run++;
    if (outs !== O_NONE || stall_cnt_o !== 4'd1) begin
      tests_failed++;
      $display("[TB] FAIL load_use_x0: outs=%b cnt=%0d expected %b cnt=1",
               outs, stall_cnt_o, O_NONE);
    end
    next_cycle_idle();
    result_src_e_i = 2'b01; rd_e_i = 5'd7; rs1_d_i = 5'd7; rs2_d_i = 5'd2;
    #1;
    tests_run++;
    if (outs !== O_LU) begin
      tests_failed++;
      $display("[TB] FAIL load_use_rs1: outs=%b expected %b", outs, O_LU);
    end
    next_cycle_idle();
    result_src_e_i = 2'b00; rd_e_i = 5'd7; rs1_d_i = 5'd7; rs2_d_i = 5'd7;
    #1;
    tests_run++;
    if (outs !== O_NONE || stall_cnt_o !== 4'd2) begin
      tests_failed++;
      $display("[TB] FAIL non_load_match: outs=%b cnt=%0d expected %b cnt=2",
               outs, stall_cnt_o, O_NONE);
    end
  endtask

  task automatic test_branch();
    clear_counter();
    pc_src_e_i = 1'b1; result_src_e_i = 2'b01; rd_e_i = 5'd5; rs2_d_i = 5'd5;
    #1;
    tests_run++;
    if (outs !== O_BR) begin
      tests_failed++;
      $display("[TB] FAIL branch_over_load_use: outs=%b expected %b", outs, O_BR);
    end
    next_cycle_idle();
    #1;
    tests_run++;
    if (outs !== O_NONE || stall_cnt_o !== 4'd0) begin
      tests_failed++;
      $display("[TB] FAIL branch_no_count: outs=%b cnt=%0d expected %b cnt=0",
               outs, stall_cnt_o, O_NONE);
    end
  endtask

  task automatic test_divide();
    clear_counter();
    mc_op_e_i = 1'b1;
    #1;
    tests_run++;
    if (outs !== O_START) begin
      tests_failed++;
      $display("[TB] FAIL div_cycle0: outs=%b expected %b", outs, O_START);
    end
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk_i);
      #1;
      tests_run++;
      if (outs !== O_BUSY) begin
        tests_failed++;
        $display("[TB] FAIL div_cycle%0d: outs=%b expected %b", c, outs, O_BUSY);
      end
    end
    @(negedge clk_i);
    mc_done_i = 1'b1;
    #1;
    tests_run++;
    if (outs !== O_NONE) begin
      tests_failed++;
      $display("[TB] FAIL div_done_cycle: outs=%b expected %b", outs, O_NONE);
    end
    next_cycle_idle();
    mc_done_i = 1'b1;
    #1;
    tests_run++;
    if (outs !== O_NONE || stall_cnt_o !== 4'd3 || mc_err_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL div_after_done: outs=%b cnt=%0d err=%b expected %b cnt=3 err=0",
               outs, stall_cnt_o, mc_err_o, O_NONE);
    end
    next_cycle_idle();
    mc_op_e_i = 1'b1;
    #1;
    tests_run++;
    if (outs !== O_START) begin
      tests_failed++;
      $display("[TB] FAIL done_in_idle_ignored: outs=%b expected %b", outs, O_START);
    end
    @(negedge clk_i);
    mc_done_i = 1'b1;
    next_cycle_idle();
  endtask

  task automatic test_timeout();
    clear_counter();
    mc_op_e_i = 1'b1;
    #1;
    tests_run++;
    if (outs !== O_START) begin
      tests_failed++;
      $display("[TB] FAIL to_cycle0: outs=%b expected %b", outs, O_START);
    end
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk_i);
      #1;
      tests_run++;
      if (outs !== O_BUSY || mc_err_o !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL to_cycle%0d: outs=%b err=%b expected %b err=0",
                 c, outs, mc_err_o, O_BUSY);
      end
    end
    @(negedge clk_i);
    #1;
    tests_run++;
    if (outs !== O_NONE || mc_err_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL to_release: outs=%b err=%b expected %b err=0",
               outs, mc_err_o, O_NONE);
    end
    next_cycle_idle();
    #1;
    tests_run++;
    if (mc_err_o !== 1'b1 || outs !== O_NONE || stall_cnt_o !== 4'd4) begin
      tests_failed++;
      $display("[TB] FAIL to_err_pulse: err=%b outs=%b cnt=%0d expected err=1 %b cnt=4",
               mc_err_o, outs, stall_cnt_o, O_NONE);
    end
    next_cycle_idle();
    #1;
    tests_run++;
    if (mc_err_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL to_err_single: err=%b expected 0", mc_err_o);
    end
    mc_op_e_i = 1'b1;
    #1;
    tests_run++;
    if (outs !== O_START) begin
      tests_failed++;
      $display("[TB] FAIL to_restart: outs=%b expected %b", outs, O_START);
    end
    @(negedge clk_i);
    mc_done_i = 1'b1;
    next_cycle_idle();
  endtask

  task automatic test_reset_busy();
    clear_counter();
    mc_op_e_i = 1'b1;
    @(negedge clk_i);
    #1;
    tests_run++;
    if (outs !== O_BUSY || stall_cnt_o !== 4'd1) begin
      tests_failed++;
      $display("[TB] FAIL rb_busy: outs=%b cnt=%0d expected %b cnt=1",
               outs, stall_cnt_o, O_BUSY);
    end
    #1;
    rst_i = 1'b1;
    #1;
    tests_run++;
    if (outs !== O_NONE || stall_cnt_o !== 4'd0 || mc_err_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL rb_async: outs=%b cnt=%0d err=%b expected %b cnt=0 err=0",
               outs, stall_cnt_o, mc_err_o, O_NONE);
    end
    @(negedge clk_i);
    #1;
    tests_run++;
    if (outs !== O_NONE) begin
      tests_failed++;
      $display("[TB] FAIL rb_held: outs=%b expected %b", outs, O_NONE);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    tests_run++;
    if (outs !== O_START) begin
      tests_failed++;
      $display("[TB] FAIL rb_restart: outs=%b expected %b", outs, O_START);
    end
    @(negedge clk_i);
    mc_done_i = 1'b1;
    next_cycle_idle();
  endtask

  task automatic test_saturation();
    int exp_cnt;
    clear_counter();
    for (int i = 0; i < 20; i++) begin
      if (i > 0) @(negedge clk_i);
      result_src_e_i = 2'b01; rd_e_i = 5'd9; rs1_d_i = 5'd9;
      #1;
      exp_cnt = (i > 15) ? 15 : i;
      tests_run++;
      if (stall_cnt_o !== 4'(exp_cnt) || outs !== O_LU) begin
        tests_failed++;
        $display("[TB] FAIL sat_cycle%0d: cnt=%0d outs=%b expected cnt=%0d %b",
                 i, stall_cnt_o, outs, exp_cnt, O_LU);
      end
    end
    @(negedge clk_i);
    cnt_clr_i = 1'b1;
    #1;
    tests_run++;
    if (stall_cnt_o !== 4'd15) begin
      tests_failed++;
      $display("[TB] FAIL sat_stuck: cnt=%0d expected 15", stall_cnt_o);
    end
    @(negedge clk_i);
    cnt_clr_i = 1'b0;
    #1;
    tests_run++;
    if (stall_cnt_o !== 4'd0) begin
      tests_failed++;
      $display("[TB] FAIL sat_clear: cnt=%0d expected 0", stall_cnt_o);
    end
    @(negedge clk_i);
    #1;
    tests_run++;
    if (stall_cnt_o !== 4'd1) begin
      tests_failed++;
      $display("[TB] FAIL sat_after_clear: cnt=%0d expected 1", stall_cnt_o);
    end
    next_cycle_idle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_divide();
    test_timeout();
    test_reset_busy();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush scheduler for the 5-stage RV32 pipeline. It drives the stall and clear inputs of the F/D, D/E and E/M pipeline registers. It resolves load-use hazards and taken-branch/jump flushes. It also sequences multi-cycle execute units (divider, FPU) through a start/done handshake FSM, and keeps a saturating stall-cycle performance counter.

Parameters:
MC_TIMEOUT, 64, max BUSY cycles before the multi-cycle op is abandoned (≥2)
CNT_W, 32, width of stall performance counter

Ports:
clk_i  in  1  core clock
rst_i  in  1  asynchronous, active-high reset
rs1_d_i  in  5  source reg 1 of instruction in Decode
rs2_d_i  in  5  source reg 2 of instruction in Decode
rd_e_i  in  5  destination reg of instruction in Execute
result_src_e_i  in  2  result select of Execute instr; 2'b01 = load
pc_src_e_i  in  1  taken branch/jump resolved in Execute
mc_op_e_i  in  1  Execute instruction needs a multi-cycle unit
mc_done_i  in  1  multi-cycle unit result valid (single-cycle pulse)
cnt_clr_i  in  1  synchronous clear of stall counter
stall_f_o  out  1  hold PC / F-D register
stall_d_o  out  1  hold F/D register
stall_e_o  out  1  hold D/E register
flush_d_o  out  1  clear F/D register
flush_e_o  out  1  clear D/E register (drives its clr_i)
flush_m_o  out  1  insert bubble into E/M register
mc_start_o  out  1  start pulse to multi-cycle unit
mc_err_o  out  1  one-cycle pulse on timeout
stall_cnt_o  out  CNT_W  stall cycles counted since reset/clear

Behaviour:
- Reset (async, rst_i=1): FSM=IDLE, timeout counter=0, stall_cnt_o=0, mc_err_o=0. All combinational outputs evaluate with FSM=IDLE.
- Reset mid-operation: the FSM drops to IDLE immediately. No mc_start_o is reissued until mc_op_e_i is sampled again in IDLE.
- FSM states: IDLE, BUSY.
  - IDLE & mc_op_e_i: mc_start_o=1 for this cycle only; next state BUSY; timeout counter loads 1.
  - BUSY & mc_done_i: next state IDLE.
  - BUSY & counter==MC_TIMEOUT & !mc_done_i: mc_err_o=1 (registered, asserted the following cycle for one cycle); next state IDLE.
  - BUSY, otherwise: counter+1.
- mc_done_i in IDLE is ignored. mc_done_i in the same cycle as mc_start_o is illegal; the unit's minimum latency is 1 cycle.
- mc_busy = (IDLE & mc_op_e_i) | (BUSY & !mc_done_i & !timeout). The timeout cycle releases the pipeline.
- Priority of outputs, highest first:
  1. mc_busy: stall_f_o=stall_d_o=stall_e_o=1, flush_m_o=1, all others 0. Load-use is suppressed because Execute is frozen.
  2. pc_src_e_i: flush_d_o=flush_e_o=1, no stalls. The load-use stall is masked because the Decode instr is squashed.
  3. load-use = (result_src_e_i==2'b01) & (rd_e_i!=0) & (rd_e_i==rs1_d_i | rd_e_i==rs2_d_i): stall_f_o=stall_d_o=1, flush_e_o=1.
  4. Otherwise all 0.
- In the mc_done_i cycle stalls are already released, so the E/M register captures the unit result on that edge.
- stall_cnt_o:
  - increments when stall_f_o=1; saturates at all-ones (no wrap).
  - cnt_clr_i has priority over increment and loads 0.
- Latency: all hazard outputs are combinational from inputs and FSM state, with zero cycles of latency. FSM and counters update on the rising edge.

Decomposition:
- Shared package (core_pkg): mc_state_t enum {IDLE, BUSY}; RESULT_SRC_LOAD=2'b01 constant; REG_ZERO=5'd0.
- No sub-module needed. An optional sat_counter sub-module (width param, inc, clr) is acceptable for stall_cnt_o and can be reused by other perf counters.

Test Plan:
1. Load-use: result_src_e_i=01, rd_e_i=5, rs2_d_i=5 -> stall_f_o=stall_d_o=flush_e_o=1 for one cycle; stall_cnt_o +1. With rd_e_i=0 -> no stall.
2. Branch plus load-use in the same cycle: pc_src_e_i=1 together with the load-use condition -> flush_d_o=flush_e_o=1, stall_f_o=0, counter unchanged.
3. Divide, done 3 cycles after start: mc_op_e_i=1 -> mc_start_o pulse in cycle 0. Stalls plus flush_m_o asserted in cycles 0–2. mc_done_i in cycle 3 -> all outputs 0 in cycle 3; FSM IDLE in cycle 4. stall_cnt_o=3.
4. Timeout with MC_TIMEOUT=4 and no mc_done_i -> stalls for 4 cycles. mc_err_o=1 for exactly one cycle afterwards; FSM IDLE. A subsequent mc_op_e_i restarts with a fresh mc_start_o.
5. Reset in BUSY: assert rst_i asynchronously mid-op -> outputs immediately in IDLE values, stall_cnt_o=0. No mc_start_o until rst_i deasserts and mc_op_e_i is sampled.
6. Saturation with CNT_W=4: hold load-use for 20 cycles -> stall_cnt_o sticks at 15. cnt_clr_i while stalling -> 0 on the next edge, then increments.
